// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns the M-mode trap CSRs, prioritises interrupts/exceptions, redirects the PC.
// Optional feature: define TRAP_VECTORED_EN for vectored interrupt targets (mtvec.MODE=1).
module trap_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h00000100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     inst_in,
    input  logic            illegal_ins_in,
    input  logic            ecall_in,
    input  logic            ebreak_in,
    input  logic            mret_in,
    input  logic            ext_irq_in,
    input  logic            sw_irq_in,
    input  logic            timer_irq_in,
    input  logic            csr_we_in,
    input  logic [11:0]     csr_addr_in,
    input  logic [XLEN-1:0] csr_wdata_in,
    output logic [XLEN-1:0] csr_rdata_out,
    output logic            trap_true_out,
    output logic [XLEN-1:0] trap_address_out,
    output logic            return_trap_out,
    output logic [XLEN-1:0] return_address_out,
    output logic            stall_out
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic [1:0] {ST_IDLE, ST_ENTER, ST_RETURN} state_t;

    state_t          state_reg;
    logic            mstatus_mie_reg;
    logic            mstatus_mpie_reg;
    logic [XLEN-1:0] mie_reg;
    logic [2:0]      irq_sync_reg;     // [2]=MEI, [1]=MTI, [0]=MSI
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [XLEN-1:0] mtval_reg;
    logic            trap_true_reg;
    logic            return_trap_reg;
    logic [XLEN-1:0] trap_address_reg;

    logic [2:0]      irq_pend;
    logic            irq_take;
    logic            exc_take;
    logic            idle_valid;
    logic            trap_take;
    logic            mret_take;
    logic [4:0]      irq_cause;
    logic [4:0]      exc_cause;
    logic [4:0]      cause_code;
    logic [XLEN-1:0] mcause_next;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mtvec_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pend
            localparam int BIT = (gi == 0) ? 3 : ((gi == 1) ? 7 : 11);
            assign irq_pend[gi] = irq_sync_reg[gi] & mie_reg[BIT];
        end
    endgenerate

    assign irq_take    = mstatus_mie_reg & (|irq_pend);
    assign exc_take    = illegal_ins_in | ecall_in | ebreak_in;
    assign idle_valid  = (state_reg == ST_IDLE) & instr_valid_in;
    assign trap_take   = idle_valid & (irq_take | exc_take);
    assign mret_take   = idle_valid & mret_in & ~(irq_take | exc_take);
    assign irq_cause   = irq_pend[2] ? 5'd11 : (irq_pend[0] ? 5'd3 : 5'd7);
    assign exc_cause   = illegal_ins_in ? 5'd2 : (ecall_in ? 5'd11 : 5'd3);
    assign cause_code  = irq_take ? irq_cause : exc_cause;
    assign mcause_next = {irq_take, {(XLEN-6){1'b0}}, cause_code};

    always_comb begin
        trap_target = {mtvec_reg[XLEN-1:2], 2'b00};
        mtvec_wdata = {csr_wdata_in[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (irq_take && mtvec_reg[1:0] == 2'b01)
            trap_target = trap_target + (XLEN'(irq_cause) << 2);
        // Only MODE 0/1 are legal; reserved encodings collapse to direct mode.
        if (csr_wdata_in[1:0] == 2'b01)
            mtvec_wdata[1:0] = 2'b01;
`endif
    end

    always_comb begin
        csr_rdata_out = '0;
        case (csr_addr_in)
            CSR_MSTATUS: csr_rdata_out = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mstatus_mpie_reg,
                                          3'b000, mstatus_mie_reg, 3'b000};
            CSR_MIE:     csr_rdata_out = mie_reg;
            CSR_MTVEC:   csr_rdata_out = mtvec_reg;
            CSR_MEPC:    csr_rdata_out = mepc_reg;
            CSR_MCAUSE:  csr_rdata_out = mcause_reg;
            CSR_MTVAL:   csr_rdata_out = mtval_reg;
            CSR_MIP:     csr_rdata_out = {{(XLEN-12){1'b0}}, irq_sync_reg[2], 3'b000,
                                          irq_sync_reg[1], 3'b000, irq_sync_reg[0], 3'b000};
            default:     csr_rdata_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            irq_sync_reg     <= '0;
            mtvec_reg        <= MTVEC_RESET;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
            trap_true_reg    <= 1'b0;
            return_trap_reg  <= 1'b0;
            trap_address_reg <= '0;
        end else begin
            irq_sync_reg    <= {ext_irq_in, timer_irq_in, sw_irq_in};
            trap_true_reg   <= 1'b0;
            return_trap_reg <= 1'b0;
            // A trap in the same cycle owns the CSRs, so the software write is dropped.
            if (csr_we_in && !trap_take) begin
                case (csr_addr_in)
                    CSR_MSTATUS: begin
                        mstatus_mie_reg  <= csr_wdata_in[3];
                        mstatus_mpie_reg <= csr_wdata_in[7];
                    end
                    CSR_MIE:    mie_reg    <= csr_wdata_in;
                    CSR_MTVEC:  mtvec_reg  <= mtvec_wdata;
                    CSR_MEPC:   mepc_reg   <= {csr_wdata_in[XLEN-1:1], 1'b0};
                    CSR_MCAUSE: mcause_reg <= csr_wdata_in;
                    CSR_MTVAL:  mtval_reg  <= csr_wdata_in;
                    default: ;
                endcase
            end
            case (state_reg)
                ST_IDLE: begin
                    if (trap_take) begin
                        mepc_reg         <= {pc_in[XLEN-1:1], 1'b0};
                        mcause_reg       <= mcause_next;
                        mtval_reg        <= (!irq_take && illegal_ins_in) ? XLEN'(inst_in) : '0;
                        mstatus_mpie_reg <= mstatus_mie_reg;
                        mstatus_mie_reg  <= 1'b0;
                        trap_address_reg <= trap_target;
                        trap_true_reg    <= 1'b1;
                        state_reg        <= ST_ENTER;
                    end else if (mret_take) begin
                        mstatus_mie_reg  <= mstatus_mpie_reg;
                        mstatus_mpie_reg <= 1'b1;
                        return_trap_reg  <= 1'b1;
                        state_reg        <= ST_RETURN;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Reset masks the pulses immediately so a redirect never escapes a reset cycle.
    assign trap_true_out      = trap_true_reg & ~reset;
    assign return_trap_out    = return_trap_reg & ~reset;
    assign trap_address_out   = trap_address_reg;
    assign return_address_out = mepc_reg;
    assign stall_out          = trap_take & ~reset;
endmodule
